stack_ctrl: RTL
===============

# stack_ctrl

Stack pointer and access controller sitting directly upstream of the CPU stack memory. It turns push/pop requests from the CPU control unit into address, write-enable and write-data for the stack RAM, returns popped words, tracks depth, full and empty, and flags overflow and underflow. After every reset it zero-fills the whole stack RAM before accepting requests.

## Interface
- `WIDTH`, 16: data word width.
- `NWORDS`, 1024: stack depth in words; power of two, ≥ 4.
- `AW` (derived, not overridable): $clog2(NWORDS).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  push request, sampled each cycle.
- `pop`  in  1  pop request, sampled each cycle.
- `push_data`  in  WIDTH  word to push.
- `err_clr`  in  1  clears sticky `ovf` and `unf`.
- `pop_data`  out  WIDTH  registered popped word.
- `pop_valid`  out  1  one-cycle pulse; `pop_data` is valid.
- `depth`  out  AW+1  words currently stored, 0..NWORDS.
- `full`  out  1  `depth == NWORDS`.
- `empty`  out  1  `depth == 0`.
- `busy`  out  1  high during post-reset clear; requests are ignored.
- `ovf`  out  1  sticky; push rejected because full.
- `unf`  out  1  sticky; pop rejected because empty.
- `mem_a`  out  AW  stack RAM address.
- `mem_we`  out  1  stack RAM write enable.
- `mem_din`  out  WIDTH  stack RAM write data.
- `mem_dout`  in  WIDTH  stack RAM read data; combinational from `mem_a`, same cycle.

## Operation
- States:
  - `INIT`: clear RAM. Reset always enters `INIT` with clear counter 0.
  - `RUN`: serve requests.
- **INIT**:
  - Drives `mem_a = cnt`, `mem_we = 1`, `mem_din = 0`; cnt increments each cycle.
  - After `cnt == NWORDS-1` is written, transitions to `RUN`.
  - `busy = 1` throughout. `push`/`pop` are ignored and never set `ovf`/`unf`.
- **Pointer**: `sp` is `depth` and points to the next free slot; the stack grows upward from address 0. Top of stack is at `sp-1`.
- **RUN**, per cycle:
  - **push only, not full**: `mem_a = sp[AW-1:0]`, `mem_we = 1`, `mem_din = push_data`; `sp += 1`.
  - **push only, full**: no write; `sp` unchanged; `ovf <= 1`.
  - **pop only, not empty**: `mem_a = sp-1`, `mem_we = 0`; `pop_data <= mem_dout`, `pop_valid <= 1`; `sp -= 1`.
  - **pop only, empty**: no access; `unf <= 1`; `pop_valid` stays 0.
  - **push+pop, not empty** (replace top, legal even when full):
    - `mem_a = sp-1`, `mem_we = 1`, `mem_din = push_data`.
    - `pop_data <= mem_dout` (old top), `pop_valid <= 1`.
    - `sp` unchanged.
  - **push+pop, empty**: treated as a plain push; `unf <= 1`.
  - **idle**: `mem_we = 0`, `mem_a = sp-1` (top-of-stack peek address; wraps to NWORDS-1 when empty).
- **Error flags**:
  - `err_clr` has priority over a same-cycle set: the flag clears.
  - A new error on the cycle after the clear sets the flag again.
- **Reset values**:
  - `sp = 0`, `pop_data = 0`, `pop_valid = 0`, `ovf = unf = 0`, `busy = 1`.
  - `empty = 1`, `full = 0`, `mem_we = 0` during the reset cycle.
- **Reset mid-operation**: any in-flight request is dropped. `INIT` restarts from address 0 even if a previous clear was partial.

## Timing
- `mem_a`, `mem_we` and `mem_din` are combinational from state and request inputs in the request cycle.
- RAM write lands at the end of the request cycle.
- `depth`, `full`, `empty`, `ovf` and `unf` update at the edge ending the request cycle.
- Pop latency is 1: request in cycle n gives `pop_data`/`pop_valid` in cycle n+1.
- Back-to-back pushes and pops are sustained at one per cycle.
- Post-reset `INIT` lasts exactly NWORDS cycles. The first request accepted is in cycle NWORDS after reset deassertion (`busy` low).

## Structure
- Shared CPU package holds:
  - state encodings `ST_INIT`, `ST_RUN`;
  - default `STACK_WIDTH = 16` and `STACK_WORDS = 1024`.
- One natural sub-module: `stack_ptr`, an up/down counter of width AW+1 with inc/dec/hold and `full`/`empty` decode.
- FSM, request decode and RAM mux stay in `stack_ctrl`.
- The RAM is not instantiated here; the CPU datapath connects `mem_*` to the stack memory.

## Test plan
- **Reset clear**: assert `reset` 1 cycle, then 1024 cycles of `busy` → `mem_we = 1`, `mem_din = 0` for addresses 0..1023 in order. `busy` falls at cycle 1024; `depth = 0`.
- **Push/pop order**: push 0x1111, 0x2222, 0x3333, then 3 pops → `pop_data` 0x3333, 0x2222, 0x1111 each one cycle after its pop; `depth` 3→0; `empty = 1`.
- **Overflow**: NWORDS=4; push 5 words → `full` after the 4th push. 5th push gives no `mem_we` and `ovf = 1`. `err_clr` → `ovf = 0`.
- **Underflow**: pop when empty → `unf = 1`, `pop_valid = 0`. Push 0xBEEF and pop in the same empty cycle → `depth = 1`, `unf = 1`.
- **Replace**: stack holding 0xAAAA, 0xBBBB; push 0xCCCC with pop → `pop_data = 0xBBBB`, `depth = 2`. A later pop returns 0xCCCC.
- **Reset mid-clear and during a push**: → `sp = 0`, `INIT` restarts at address 0, no `ovf`/`unf` set.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared CPU definitions for the stack controller: FSM state encoding and default geometry.
package stack_ctrl_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } stack_state_t;

   localparam int STACK_WIDTH = 16;
   localparam int STACK_WORDS = 1024;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer: up/down counter holding the current depth, with full/empty decode.
module stack_ptr
   import stack_ctrl_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   input  logic        dec,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);

   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [AW:0] count_r;

   // Depth counter; simultaneous inc and dec hold the value
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
      end else if (inc && !dec) begin
         count_r <= count_r + (AW+1)'(1);
      end else if (dec && !inc) begin
         count_r <= count_r - (AW+1)'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // Reset forces the flags to their idle values even before the counter clears
   assign count = count_r;
   assign full  = !reset && (count_r == FULL_CNT);
   assign empty = reset || (count_r == '0);

endmodule

// File: rtl/stack_ctrl.sv
// CPU stack controller: post-reset RAM clear, push/pop/replace decode and RAM port mux.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter int  WIDTH  = STACK_WIDTH,
   parameter int  NWORDS = STACK_WORDS,
   localparam int AW     = $clog2(NWORDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   input  logic             err_clr,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   output logic [AW:0]      depth,
   output logic             full,
   output logic             empty,
   output logic             busy,
   output logic             ovf,
   output logic             unf,
   output logic [AW-1:0]    mem_a,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_din,
   input  logic [WIDTH-1:0] mem_dout
);

   stack_state_t     state_r;
   logic [AW-1:0]    cnt_r;
   logic [WIDTH-1:0] pop_data_r;
   logic             pop_valid_r;
   logic             ovf_r;
   logic             unf_r;

   logic [AW:0]      sp_s;
   logic             full_s;
   logic             empty_s;
   logic [AW-1:0]    top_a_s;
   logic             inc_s;
   logic             dec_s;
   logic             take_s;
   logic             ovf_set_s;
   logic             unf_set_s;

   stack_ptr #(.AW(AW)) u_ptr (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_s),
      .dec   (dec_s),
      .count (sp_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Top-of-stack address; wraps to NWORDS-1 when empty, which is harmless as a peek
   assign top_a_s = sp_s[AW-1:0] - AW'(1);

   // Request decode and RAM port mux
   always_comb begin
      mem_a     = top_a_s;
      mem_we    = 1'b0;
      mem_din   = '0;
      inc_s     = 1'b0;
      dec_s     = 1'b0;
      take_s    = 1'b0;
      ovf_set_s = 1'b0;
      unf_set_s = 1'b0;
      if (reset) begin
         mem_we = 1'b0;
      end else if (state_r == ST_INIT) begin
         mem_a  = cnt_r;
         mem_we = 1'b1;
      end else if (push && pop && !empty_s) begin
         mem_we  = 1'b1;
         mem_din = push_data;
         take_s  = 1'b1;
      end else if (push) begin
         if (!full_s) begin
            mem_a   = sp_s[AW-1:0];
            mem_we  = 1'b1;
            mem_din = push_data;
            inc_s   = 1'b1;
         end else begin
            ovf_set_s = 1'b1;
         end
         unf_set_s = pop;
      end else if (pop) begin
         if (!empty_s) begin
            dec_s  = 1'b1;
            take_s = 1'b1;
         end else begin
            unf_set_s = 1'b1;
         end
      end else begin
         mem_a = top_a_s;
      end
   end

   // FSM with clear counter, pop return register and sticky error flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_INIT;
         cnt_r       <= '0;
         pop_data_r  <= '0;
         pop_valid_r <= 1'b0;
         ovf_r       <= 1'b0;
         unf_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               cnt_r <= cnt_r + AW'(1);
               if (cnt_r == AW'(NWORDS - 1)) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_INIT;
               end
            end
            ST_RUN: begin
               cnt_r   <= cnt_r;
               state_r <= ST_RUN;
            end
            default: begin
               cnt_r   <= '0;
               state_r <= ST_INIT;
            end
         endcase
         pop_valid_r <= take_s;
         if (take_s) begin
            pop_data_r <= mem_dout;
         end else begin
            pop_data_r <= pop_data_r;
         end
         ovf_r <= err_clr ? 1'b0 : (ovf_r | ovf_set_s);
         unf_r <= err_clr ? 1'b0 : (unf_r | unf_set_s);
      end
   end

   assign pop_data  = pop_data_r;
   assign pop_valid = pop_valid_r;
   assign depth     = sp_s;
   assign full      = full_s;
   assign empty     = empty_s;
   assign busy      = reset || (state_r == ST_INIT);
   assign ovf       = ovf_r;
   assign unf       = unf_r;

endmodule
